// File: rtl/parity_rx_pkg.sv
// Shared types and width helpers for the parity-checked serial receiver.
package parity_rx_pkg;

    // Receiver frame states, in the order a frame moves through them.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Width of the per-bit clock counter; it only ever holds CLKS_PER_BIT-1 or less.
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    // Width of the data bit index; a one-bit word still needs a one-bit index.
    function automatic int idx_width(input int data_bits);
        return (data_bits > 1) ? $clog2(data_bits) : 1;
    endfunction

endpackage

// File: rtl/parity_rx_sync.sv
// Two-flop synchronizer for an asynchronous pin input, with a selectable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Handshake: out_data/out_perr are meaningful only while out_valid=1 and stay stable
// until a cycle with out_valid & out_ready; a word moves on the edge ending that cycle.
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_perr,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = idx_width(DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = (ODD_PARITY != 0);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 tick;
    logic                 commit;
    logic                 stop_bad;
    logic                 can_load;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick     = (bit_cnt_q == '0);
    assign can_load = !out_valid || out_ready;
    assign busy     = (state_q != IDLE);

    // Frame state, bit timer, bit index, shift register and parity result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
        end
    end

    // Next-state logic: the first timeout lands mid start bit, later ones mid bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        commit    = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    bit_cnt_d = HALF_LOAD;
                    state_d   = START;
                end
            end
            START: begin
                if (!tick) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = FULL_LOAD;
                    idx_d     = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (!tick) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else begin
                    shreg_d[idx_q] = rx_s;
                    bit_cnt_d      = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else begin
                    perr_d    = (^shreg_q) ^ rx_s ^ ODD_BIT;
                    bit_cnt_d = FULL_LOAD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else if (rx_s) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stop_bad = 1'b1;
                    state_d  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output buffer: a commit refills it (even while it is being drained), otherwise it drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= commit && !can_load;
            if (commit && can_load) begin
                out_data  <= shreg_q;
                out_perr  <= perr_q;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
